// File: rtl/mem_io_pkg.sv
// mem_io_pkg: I/O window decode constants and the read-data source select type.
package mem_io_pkg;
  localparam logic [1:0] IO_SEL      = 2'b11;
  localparam logic [2:0] IO_OFS_UART = 3'd0;
  localparam logic [2:0] IO_OFS_CLK  = 3'd4;
  typedef enum logic {SEL_RAM, SEL_IO} rd_sel_t;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO for the UART TX path; a push alongside a pop is accepted even when full.
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != FULL) | do_pop);
  assign dout    = (count != '0) ? mem[rd_ptr] : 8'h00;
  always_ff @(posedge clk_in)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: decodes CPU byte accesses to RAM or the 0x30000 I/O window
// (UART TX/RX, cycle counter snapshot, stop flag); all reads return one cycle later.
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [31:0]       cpu_a,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_din,
  output logic              io_buffer_full,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_pop,
  output logic              program_finished
);
  localparam int CW = $clog2(TX_DEPTH) + 1;
  logic is_io, io_wr, io_rd, push, unused_a;
  logic [2:0] ofs;
  logic [7:0] io_next, io_rdata, push_data;
  logic [31:0] cnt, snap;
  logic [CW-1:0] tx_count;
  rd_sel_t sel;
  assign is_io     = cpu_a[17:16] == IO_SEL;
  assign ofs       = cpu_a[2:0];
  assign unused_a  = ^cpu_a[31:18];
  assign ram_en    = rdy_in & ~is_io;
  assign ram_wr    = ram_en & cpu_wr;
  assign ram_a     = cpu_a[RAM_AW-1:0];
  assign ram_dout  = cpu_dout;
  assign io_wr     = rdy_in & is_io & cpu_wr;
  assign io_rd     = rdy_in & is_io & ~cpu_wr;
  assign rx_pop    = io_rd & (ofs == IO_OFS_UART) & rx_valid;
  assign push      = io_wr & ((ofs == IO_OFS_CLK) | ((ofs == IO_OFS_UART) & (cpu_dout != 8'h00)));
  assign push_data = (ofs == IO_OFS_CLK) ? 8'h00 : cpu_dout;
  // offset 4 reads the live counter while it is being snapshotted; 5..7 read the snapshot
  assign io_next   = (ofs == IO_OFS_UART) ? (rx_valid ? rx_data : 8'h00) :
                     (ofs == IO_OFS_CLK)  ? cnt[7:0] :
                     ofs[2]               ? snap[{ofs[1:0], 3'b000} +: 8] : 8'h00;
  assign cpu_din        = (sel == SEL_RAM) ? ram_din : io_rdata;
  assign tx_valid       = tx_count != '0;
  assign io_buffer_full = tx_count >= CW'(TX_DEPTH - 1);
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      cnt              <= '0;
      snap             <= '0;
      sel              <= SEL_RAM;
      io_rdata         <= '0;
      program_finished <= 1'b0;
    end else if (rdy_in) begin
      cnt <= cnt + 32'd1;
      if (!cpu_wr) begin
        sel      <= is_io ? SEL_IO : SEL_RAM;
        io_rdata <= io_next;
      end
      if (io_rd && ofs == IO_OFS_CLK) snap <= cnt;
      if (io_wr && ofs == IO_OFS_CLK) program_finished <= 1'b1;
    end
  tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (push),
    .din    (push_data),
    .pop    (tx_ready),
    .dout   (tx_data),
    .count  (tx_count)
  );
endmodule
